// File: rtl/oka_pkg.sv
// Shared types and helpers for the sequential 32-bit carry-less Karatsuba multiplier.
// Holds widths, the controller state encoding and the XOR-only recombination function.
package oka_pkg;

  localparam int W = 32;
  localparam int H = W / 2;

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    DONE
  } oka_seq_state_t;

  // z0 = lo*lo, z1 = (hi^lo)*(hi^lo), z2 = hi*hi; mid term is z1 with z0 and z2 removed.
  function automatic logic [2*W-2:0] oka_combine(input logic [2*H-2:0] z0,
                                                  input logic [2*H-2:0] z1,
                                                  input logic [2*H-2:0] z2);
    logic [2*H-2:0] mid;
    mid = z0 ^ z1 ^ z2;
    return {{W{1'b0}}, z0}
         ^ {{H{1'b0}}, mid, {H{1'b0}}}
         ^ {z2, {W{1'b0}}};
  endfunction

endpackage

// File: rtl/oka_32bit_seq_if.sv
// Requester handshake, result handshake and shared half-width multiplier bus.
// The slave modport is the multiplier controller; the master modport is its parent.
interface oka_32bit_seq_if #(
  parameter int W = oka_pkg::W
);
  localparam int H = W / 2;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] y;
  logic [H-1:0]   mul_a;
  logic [H-1:0]   mul_b;
  logic [2*H-2:0] mul_y;
  logic           busy;

  modport slave (
    input  in_valid, a, b, out_ready, mul_y,
    output in_ready, out_valid, y, mul_a, mul_b, busy
  );

  modport master (
    output in_valid, a, b, out_ready, mul_y,
    input  in_ready, out_valid, y, mul_a, mul_b, busy
  );

endinterface

// File: rtl/oka_recombine_32bit.sv
// Combinational Karatsuba recombination of three 31-bit partial products into a 63-bit product.
// Zero latency, no handshake: pure XOR network.
module oka_recombine_32bit
  import oka_pkg::*;
(
  input  logic [2*H-2:0] i_z0,
  input  logic [2*H-2:0] i_z1,
  input  logic [2*H-2:0] i_z2,
  output logic [2*W-2:0] o_y
);

  assign o_y = oka_combine(i_z0, i_z1, i_z2);

endmodule

// File: rtl/oka_32bit_seq.sv
// Sequential 32x32 carry-less Karatsuba multiplier sharing one external 16-bit multiplier over P0..P2.
// Result 4 cycles after accept; holds y in DONE until out_ready, taking a new request in that same cycle.
module oka_32bit_seq #(
  parameter int W = oka_pkg::W
) (
  input  logic            clk,
  input  logic            rst_n,
  oka_32bit_seq_if.slave  bus
);
  import oka_pkg::*;

  localparam int H = W / 2;

  oka_seq_state_t r_state;
  oka_seq_state_t w_state_nxt;

  logic [W-1:0]   r_ra;
  logic [W-1:0]   r_rb;
  logic [2*H-2:0] r_z0;
  logic [2*H-2:0] r_z1;
  logic [2*H-2:0] r_z2;
  logic [2*W-2:0] r_y;
  logic           r_out_vld;
  logic           r_live;

  logic           w_in_rdy;
  logic           w_accept;
  logic [H-1:0]   w_mul_a;
  logic [H-1:0]   w_mul_b;
  logic [2*H-2:0] w_z2_sel;
  logic [2*W-2:0] w_y_comb;

  // r_live keeps in_ready low until the first edge after reset release.
  assign w_in_rdy = r_live && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
  assign w_accept = bus.in_valid && w_in_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_mul_a     = '0;
    w_mul_b     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = P0;
        end
      end
      P0: begin
        w_mul_a     = r_ra[H-1:0];
        w_mul_b     = r_rb[H-1:0];
        w_state_nxt = P1;
      end
      P1: begin
        w_mul_a     = r_ra[W-1:H] ^ r_ra[H-1:0];
        w_mul_b     = r_rb[W-1:H] ^ r_rb[H-1:0];
        w_state_nxt = P2;
      end
      P2: begin
        w_mul_a     = r_ra[W-1:H];
        w_mul_b     = r_rb[W-1:H];
        w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = w_accept ? P0 : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // In P2 the high-half product is still on the bus, so recombine from mul_y directly.
  assign w_z2_sel = (r_state == P2) ? bus.mul_y : r_z2;

  oka_recombine_32bit u_recombine (
    .i_z0 (r_z0),
    .i_z1 (r_z1),
    .i_z2 (w_z2_sel),
    .o_y  (w_y_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra      <= '0;
      r_rb      <= '0;
      r_z0      <= '0;
      r_z1      <= '0;
      r_z2      <= '0;
      r_y       <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ra <= bus.a;
        r_rb <= bus.b;
      end
      case (r_state)
        P0: r_z0 <= bus.mul_y;
        P1: r_z1 <= bus.mul_y;
        P2: begin
          r_z2      <= bus.mul_y;
          r_y       <= w_y_comb;
          r_out_vld <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_vld <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = r_out_vld;
  assign bus.y         = r_y;
  assign bus.mul_a     = w_mul_a;
  assign bus.mul_b     = w_mul_b;
  assign bus.busy      = (r_state != IDLE);

  a_y_only_from_p2: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != P2) |=> $stable(r_y));

  a_vld_in_done: assert property (@(posedge clk) disable iff (!rst_n)
    r_out_vld == (r_state == DONE));

endmodule

// File: tb/tb_oka_32bit_seq.sv
// Bench for oka_32bit_seq: golden 16-bit carry-less multiplier on the shared bus, scoreboard
// built from the textbook shift-and-XOR product, directed vectors plus randomized streams.
module tb_oka_32bit_seq;
  import oka_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  oka_32bit_seq_if bus ();

  oka_32bit_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int acc_cyc[$];
  int res_cyc[$];

  function automatic logic [62:0] clmul(input logic [31:0] x, input logic [31:0] z);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (z[i]) r = r ^ (63'(x) << i);
    end
    return r;
  endfunction

  logic [62:0] mul_full;
  assign mul_full  = clmul({16'h0, bus.mul_a}, {16'h0, bus.mul_b});
  assign bus.mul_y = mul_full[30:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one request, returns the result, cycles from accept to out_valid and the bus sequence.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [62:0] yv, output int lat,
                        output logic [47:0] ma, output logic [47:0] mb);
    int k;
    yv = '0;
    ma = '0;
    mb = '0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b0;
    #1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      #1;
      if (lat == 1) bus.in_valid = 1'b0;
      if (lat <= 3) begin
        ma[16*(lat-1) +: 16] = bus.mul_a;
        mb[16*(lat-1) +: 16] = bus.mul_b;
      end
      if (bus.out_valid) break;
    end
    yv = bus.y;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("consumed_vld", 64'(bus.out_valid), 64'd0);
  endtask

  // Randomized request/result streams checked against a queue of reference products.
  task automatic stream(input int n, input int pv, input int pr);
    logic [62:0] exp_q[$];
    logic [62:0] last_y;
    bit          last_pending;
    bit          acc;
    int          sent;
    int          got;
    int          cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    acc = 1'b0;
    last_pending = 1'b0;
    last_y = '0;
    acc_cyc.delete();
    res_cyc.delete();
    @(negedge clk);
    while (got < n && cyc < n * 20 + 100) begin
      if (!(bus.in_valid && !acc)) begin
        if (sent < n && $urandom_range(99) < pv) begin
          bus.in_valid = 1'b1;
          bus.a = ($urandom_range(15) == 0) ? 32'h0 : $urandom;
          bus.b = ($urandom_range(15) == 0) ? 32'h0 : $urandom;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(99) < pr);
      #1;
      if (last_pending) begin
        check("hold_vld", 64'(bus.out_valid), 64'd1);
        check("hold_y", 64'(bus.y), 64'(last_y));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(bus.y), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("stream_y", 64'(bus.y), 64'(exp_q.pop_front()));
        end
        res_cyc.push_back(cyc);
        got++;
        last_pending = 1'b0;
      end else begin
        last_pending = bus.out_valid;
        last_y = bus.y;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        exp_q.push_back(clmul(bus.a, bus.b));
        acc_cyc.push_back(cyc);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_count", 64'(got), 64'(n));
    check("stream_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [62:0] y;
  } vec_t;

  vec_t        vt[7];
  logic [62:0] yv;
  int          lat;
  logic [47:0] ma;
  logic [47:0] mb;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [62:0] y_hold;
  bit          stable_ok;
  bit          rdy_ok;

  initial begin
    vt[0] = '{32'h0000_0003, 32'h0000_0003, 63'h5};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 63'h5555_5555_5555_5555};
    vt[2] = '{32'h0001_0000, 32'h0001_0000, 63'h1_0000_0000};
    vt[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 63'h0};
    vt[4] = '{32'h0000_0003, 32'h0000_0005, 63'hF};
    vt[5] = '{32'h0000_0001, 32'h8000_0000, 63'h8000_0000};
    vt[6] = '{32'h8000_0000, 32'h8000_0000, 63'h4000_0000_0000_0000};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_y", 64'(bus.y), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rdy_after_edge", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, yv, lat, ma, mb);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d_y", i), 64'(yv), 64'(vt[i].y));
      if (i == 0) begin
        check("vec0_mul_a", 64'(ma), 64'h0000_0003_0003);
        check("vec0_mul_b", 64'(mb), 64'h0000_0003_0003);
      end
      consume();
    end

    // Backpressure: result held for 10 cycles while a competing request waits.
    run_op(32'hCAFE_BABE, 32'h1357_9BDF, yv, lat, ma, mb);
    check("bp_y", 64'(yv), 64'(clmul(32'hCAFE_BABE, 32'h1357_9BDF)));
    y_hold = yv;
    stable_ok = 1'b1;
    rdy_ok = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'h1111_2222;
    bus.b = 32'h3333_4444;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.y !== y_hold || bus.out_valid !== 1'b1) stable_ok = 1'b0;
      if (bus.in_ready !== 1'b0) rdy_ok = 1'b0;
    end
    check("bp_stable", 64'(stable_ok), 64'd1);
    check("bp_in_ready_low", 64'(rdy_ok), 64'd1);
    bus.in_valid = 1'b0;
    consume();
    check("bp_idle_after", 64'(bus.busy), 64'd0);
    check("bp_y_kept", 64'(bus.y), 64'(y_hold));

    // Back-to-back: accepts land on the DONE cycle, one result every 4 cycles.
    stream(8, 100, 100);
    for (int i = 1; i < 8; i++) begin
      if (i < acc_cyc.size()) check($sformatf("b2b_acc_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
      if (i < res_cyc.size()) check($sformatf("b2b_res_gap%0d", i), 64'(res_cyc[i] - res_cyc[i-1]), 64'd4);
    end

    // Reset in the middle of an operation.
    run_op(32'hA5A5_0F0F, 32'h0102_0304, yv, lat, ma, mb);
    consume();
    ra = 32'hDEAD_1234;
    rb = 32'h0BAD_F00D;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = ra;
    bus.b = rb;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_busy", 64'(bus.busy), 64'd1);
    check("mid_p1_mul_a", 64'(bus.mul_a), 64'(ra[31:16] ^ ra[15:0]));
    check("mid_p1_mul_b", 64'(bus.mul_b), 64'(rb[31:16] ^ rb[15:0]));
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", 64'(bus.y), 64'd0);
    check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, yv, lat, ma, mb);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_y", 64'(yv), 64'(clmul(32'h1234_5678, 32'h9ABC_DEF0)));
    consume();

    stream(6000, 85, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
